// File: rtl/dct16_pkg.sv
// Shared constants and types for the 16-point DCT datapath.
package dct16_pkg;

  localparam int DCT16_N     = 16;
  localparam int DCT16_HALF  = 8;
  localparam int DCT16_IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

  // Partner index of a butterfly pair: 15 - i.
  function automatic logic [DCT16_IDX_W-1:0] mirror_idx(input logic [DCT16_IDX_W-1:0] idx);
    return 4'd15 - idx;
  endfunction

endpackage

// File: rtl/dct16_pingpong_buf.sv
// Two 16-entry sample banks: one written by the input side while the other
// is read as butterfly pairs (i, 15-i) by the output side.
module dct16_pingpong_buf
  import dct16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic                   wr_bank,
  input  logic [DCT16_IDX_W-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_bank,
  input  logic [DCT16_IDX_W-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]  rd_lo,
  output logic [DATA_WIDTH-1:0]  rd_hi
);

  logic [DATA_WIDTH-1:0] mem [2][DCT16_N];

  // Bank storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
  end

  assign rd_lo = mem[rd_bank][rd_idx];
  assign rd_hi = mem[rd_bank][mirror_idx(rd_idx)];

endmodule

// File: rtl/dct16_stage1_butterfly.sv
// DCT16 stage 1: frames serial samples into ping-pong banks and streams out
// s[0..7] then d[0..7]. Optional frame_err port under DCT16_S1_ERR_EN.
module dct16_stage1_butterfly
  import dct16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_sample,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic [DATA_WIDTH:0]   out_sample
`ifdef DCT16_S1_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  logic [DCT16_IDX_W-1:0] wr_idx;
  logic                   bank_ptr;
  logic                   pending;
  rd_state_t              state;
  logic [DCT16_IDX_W-1:0] rd_cnt;

  logic [DCT16_IDX_W-1:0] wr_addr;
  logic                   complete;
  logic [DCT16_IDX_W-1:0] rd_sel;
  logic                   emit;
  logic                   last;
  logic [DATA_WIDTH-1:0]  rd_lo;
  logic [DATA_WIDTH-1:0]  rd_hi;
  logic [DATA_WIDTH:0]    lo_ext;
  logic [DATA_WIDTH:0]    hi_ext;
  logic [DATA_WIDTH:0]    result;

  // Write addressing, frame completion and the butterfly datapath.
  always_comb begin
    wr_addr  = in_sof ? 4'd0 : wr_idx;
    complete = in_valid && !in_sof && (wr_idx == 4'd15);
    rd_sel   = (state == IDLE) ? 4'd0 : rd_cnt;
    emit     = (state == DRAIN) || pending;
    last     = (state == DRAIN) && (rd_cnt == 4'd15);
    lo_ext   = {rd_lo[DATA_WIDTH-1], rd_lo};
    hi_ext   = {rd_hi[DATA_WIDTH-1], rd_hi};
    if (rd_sel[3]) begin
      result = lo_ext - hi_ext;
    end else begin
      result = lo_ext + hi_ext;
    end
  end

  dct16_pingpong_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .wr_en   (in_valid),
    .wr_bank (bank_ptr),
    .wr_idx  (wr_addr),
    .wr_data (in_sample),
    .rd_bank (~bank_ptr),
    .rd_idx  ({1'b0, rd_sel[2:0]}),
    .rd_lo   (rd_lo),
    .rd_hi   (rd_hi)
  );

  // Write index and bank pointer; in_sof restarts the frame at index 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx   <= 4'd0;
      bank_ptr <= 1'b0;
    end else if (in_valid) begin
      wr_idx <= in_sof ? 4'd1 : wr_idx + 4'd1;
      if (complete) begin
        bank_ptr <= ~bank_ptr;
      end
    end
  end

`ifdef DCT16_S1_ERR_EN
  // Flags an in_sof that discards a partially written frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= in_valid && in_sof && (wr_idx != 4'd0);
    end
  end
`endif

  // Readout FSM with registered outputs; a frame completing on the last
  // drain cycle chains straight into the next drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_cnt     <= 4'd0;
      pending    <= 1'b0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_sample <= '0;
    end else begin
      out_valid  <= emit;
      out_sof    <= emit && (rd_sel == 4'd0);
      out_sample <= emit ? result : '0;
      case (state)
        IDLE: begin
          if (pending) begin
            state   <= DRAIN;
            rd_cnt  <= 4'd1;
            pending <= complete;
          end else begin
            pending <= complete;
          end
        end
        DRAIN: begin
          rd_cnt <= rd_cnt + 4'd1;
          if (last) begin
            if (pending || complete) begin
              pending <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (complete) begin
            pending <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          rd_cnt  <= 4'd0;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct16_stage1_butterfly.sv
// Directed self-checking bench for dct16_stage1_butterfly.
module tb_dct16_stage1_butterfly;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_sof;
  logic [15:0] in_sample;
  logic        out_valid;
  logic        out_sof;
  logic [16:0] out_sample;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc;
  int first_acc;
  int err_pulses = 0;
  int q_val[$];
  bit q_sof[$];
  int q_cyc[$];
  int exp_a[16];
  int exp_b[16];
  int exp_c[16];

  dct16_stage1_butterfly #(.DATA_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_sample (out_sample)
`ifdef DCT16_S1_ERR_EN
    ,
    .frame_err  (frame_err)
`endif
  );

`ifndef DCT16_S1_ERR_EN
  assign frame_err = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      q_val.push_back(int'($signed(out_sample)));
      q_sof.push_back(out_sof);
      q_cyc.push_back(cyc);
    end
    if (frame_err) err_pulses = err_pulses + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d);
    in_valid  = v;
    in_sof    = s;
    in_sample = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // x[i] = i + off, with optional sof and 'gap' idle cycles between samples.
  task automatic feed(input int off, input int gap, input bit use_sof);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, use_sof && (i == 0), 16'(i + off));
      if (i < 15) idle(gap);
    end
    acc_cyc = cyc;
  endtask

  function automatic void ramp_exp(input int off, output int e[16]);
    for (int k = 0; k < 16; k++) e[k] = (k < 8) ? (15 + 2 * off) : (2 * (k - 8) - 15);
  endfunction

  task automatic check_frame(input string tag, input int base, input int e[16], input int first);
    chk({tag, "_count"}, (q_val.size() >= base + 16) ? 1 : 0, 1);
    if (q_val.size() >= base + 16) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("%s_val%0d", tag, k), q_val[base + k], e[k]);
        chk($sformatf("%s_sof%0d", tag, k), int'(q_sof[base + k]), (k == 0) ? 1 : 0);
        chk($sformatf("%s_cyc%0d", tag, k), q_cyc[base + k], first + k);
      end
    end
  endtask

  task automatic clear_q();
    q_val.delete();
    q_sof.delete();
    q_cyc.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_sample = 16'd0;
    idle(3);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sof", int'(out_sof), 0);
    chk("rst_sample", int'(out_sample), 0);
    chk("rst_err", int'(frame_err), 0);
    rst_n = 1'b1;
    idle(2);
    clear_q(); err_pulses = 0;

    // Ramp
    ramp_exp(0, exp_a);
    feed(0, 0, 1'b1);
    idle(20);
    chk("ramp_total", q_val.size(), 16);
    check_frame("ramp", 0, exp_a, acc_cyc + 1);
`ifdef DCT16_S1_ERR_EN
    chk("ramp_noerr", err_pulses, 0);
`endif
    clear_q();

    // Extremes
    for (int k = 0; k < 16; k++) exp_b[k] = (k < 8) ? -1 : 65535;
    for (int i = 0; i < 16; i++) drive(1'b1, i == 0, (i < 8) ? 16'h7FFF : 16'h8000);
    acc_cyc = cyc;
    idle(20);
    chk("ext_total", q_val.size(), 16);
    check_frame("ext", 0, exp_b, acc_cyc + 1);
    clear_q();

    // Back-to-back frames
    ramp_exp(100, exp_b);
    ramp_exp(300, exp_c);
    feed(0, 0, 1'b1);
    first_acc = acc_cyc;
    feed(100, 0, 1'b1);
    feed(300, 0, 1'b1);
    idle(20);
    chk("b2b_total", q_val.size(), 48);
    check_frame("b2b0", 0, exp_a, first_acc + 1);
    check_frame("b2b1", 16, exp_b, first_acc + 17);
    check_frame("b2b2", 32, exp_c, first_acc + 33);
    clear_q();

    // Sparse input
    feed(0, 2, 1'b1);
    idle(20);
    chk("sparse_total", q_val.size(), 16);
    check_frame("sparse", 0, exp_a, acc_cyc + 1);
    clear_q();

    // Truncation
    err_pulses = 0;
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 16'(1000 + i));
    feed(0, 0, 1'b1);
    idle(20);
    chk("trunc_total", q_val.size(), 16);
    check_frame("trunc", 0, exp_a, acc_cyc + 1);
`ifdef DCT16_S1_ERR_EN
    chk("trunc_err", err_pulses, 1);
`endif
    clear_q();

    // Reset mid-drain, with a partial next frame in flight
    feed(0, 0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 16'd500);
    for (int i = 0; i < 40; i++) begin
      if (q_val.size() >= 6) break;
      idle(1);
    end
    chk("rst6_reached", (q_val.size() >= 6) ? 1 : 0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_sample", int'(out_sample), 0);
    chk("mid_rst_sof", int'(out_sof), 0);
    rst_n = 1'b1;
    clear_q();
    idle(20);
    chk("mid_rst_flushed", q_val.size(), 0);
    feed(0, 0, 1'b0);
    idle(20);
    chk("post_rst_total", q_val.size(), 16);
    check_frame("post_rst", 0, exp_a, acc_cyc + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
